first_wire_adder: RTL and testbench
===================================

Name: first_wire_adder

Overview:
- Host-controlled demo block: a 16-bit host bus carries wire-in endpoints into the FPGA and wire-out endpoints back to the host.
- Core function: the host writes two 16-bit operands, and the block returns their 16-bit sum (mod 2^16).
- Also drives 8 LEDs from a host wire and reports 4 push-buttons to the host.
- Sits at the FPGA top level and connects directly to the host-interface pins.

Parameters:
- none; all widths are fixed at 16-bit endpoints and 8-bit addresses.

Ports:
- hi_in[0] (hi_clk)  in  1  sole clock; all logic is on its rising edge.
- hi_in[1] (hi_reset)  in  1  asynchronous, active-high reset.
- hi_in[7:2]  in  6  host strobes: [2] wr, [3] rd, [4] addr, [5] upd_wi, [6] upd_wo, [7] reserved (ignored).
- hi_out  out  2  [0] rd_valid, [1] ready.
- hi_inout  inout  16  bidirectional data/address bus.
- led  out  8  active-low LEDs.
- button  in  4  active-low push-buttons.

Behaviour:
- Reset (async assert; deassert takes effect on the next edge):
  - address register = 0x00; all shadow and active wire-ins = 0x0000; wire-out snapshots = 0x0000.
  - rd_valid = 0, ready = 0, hi_inout = Z, led = 8'hFF (all LEDs off).
- ready = 1 from the first clock edge after reset deasserts.
- Address phase: when addr = 1, hi_inout[7:0] is latched into the address register.
- Write:
  - When wr = 1, hi_inout is written to the shadow register of the latched address.
  - Valid wire-in addresses are 0x00, 0x01 and 0x02; writes to any other address are ignored.
- Strobe priority within one cycle: addr > wr > rd; lower-priority strobes in that cycle are ignored.
  - upd_wi and upd_wo are independent of that priority.
- upd_wi: copies all shadows to the active registers at this edge.
  - A shadow written in the same cycle is NOT included; it commits on the next upd_wi.
- upd_wo: captures snapshots at this edge.
  - ep20 = {12'h000, ~button}, with button sampled via a 2-flop synchroniser.
  - ep21 = (active01 + active02) mod 2^16; the adder is combinational, carry discarded.
  - upd_wi and upd_wo in the same cycle: the snapshot uses the pre-commit values.
  - upd_wo one or more cycles after upd_wi sees the new sum.
- Read:
  - rd = 1 at edge N: on the cycle following edge N, rd_valid = 1 and hi_inout drives the snapshot of the latched address.
  - Snapshot addresses are 0x20 and 0x21; any other address returns 0x0000.
  - Reads return snapshots only, never live values.
- hi_inout is driven only while rd_valid = 1 and is Z otherwise; the host must not drive the bus in that cycle.
- led = ~active00[7:0]; active00[15:8] is unused.
- Back-to-back reads on consecutive cycles are allowed, one result per cycle.
- Reset mid-transaction: any pending read is cancelled and the bus is released immediately.

Decomposition:
- Shared package holds:
  - endpoint address constants: EP_LED 0x00, EP_A 0x01, EP_B 0x02, EP_BTN 0x20, EP_SUM 0x21.
  - strobe bit indices for hi_in.
  - 16-bit word typedef.
- One sub-module, first_host_if, owns:
  - address latch, shadow/active wire-in banks, snapshot registers, read/tristate control.
  - The top level holds the adder, LED and button logic.

Test Plan:
- Reset asserted mid-run -> led=8'hFF, hi_inout=Z, rd_valid=0, ready=0; ready=1 one cycle after release.
- Add: write 0x01=0x1234 and 0x02=0x4321, upd_wi, upd_wo, read 0x21 -> 0x5555 with rd_valid=1 for exactly one cycle.
- Overflow: operands 0xFFFF + 0x0002 -> read 0x21 returns 0x0001; operands 0x8000 + 0x8000 -> 0x0000.
- Staging:
  - Write 0x01=0x0005 without upd_wi, then upd_wo and read 0x21 -> returns the old sum.
  - After upd_wi and upd_wo -> returns the new sum.
  - upd_wi and upd_wo in the same cycle -> old sum.
- Buttons and LEDs: button=4'b1010, upd_wo, read 0x20 -> 0x0005; write 0x00=0x00A5, upd_wi -> led=8'h5A.
- Bus rules:
  - Read 0x33 -> 0x0000.
  - Write 0x21=0xBEEF -> sum unchanged.
  - wr and rd in the same cycle -> write taken, no rd_valid.
  - Random loop of 5 operand pairs -> every read equals (a+b) mod 65536.

Source files
------------

// File: rtl/first_wire_adder_pkg.sv
// Shared definitions for the first_wire_adder host-endpoint demo: endpoint
// addresses, host strobe bit positions and the host operation decode.
package first_wire_adder_pkg;

  typedef logic [15:0] word_t;
  typedef logic [7:0]  addr_t;

  localparam addr_t EP_LED = 8'h00;
  localparam addr_t EP_A   = 8'h01;
  localparam addr_t EP_B   = 8'h02;
  localparam addr_t EP_BTN = 8'h20;
  localparam addr_t EP_SUM = 8'h21;

  localparam int unsigned HI_CLK    = 0;
  localparam int unsigned HI_RST    = 1;
  localparam int unsigned HI_WR     = 2;
  localparam int unsigned HI_RD     = 3;
  localparam int unsigned HI_ADDR   = 4;
  localparam int unsigned HI_UPD_WI = 5;
  localparam int unsigned HI_UPD_WO = 6;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_ADDR,
    OP_WRITE,
    OP_READ
  } host_op_e;

  // addr outranks wr, which outranks rd; only one of them acts per cycle
  function automatic host_op_e decode_op(input logic addr, input logic wr, input logic rd);
    if (addr)    return OP_ADDR;
    else if (wr) return OP_WRITE;
    else if (rd) return OP_READ;
    else         return OP_NONE;
  endfunction

endpackage

// File: rtl/first_host_if.sv
// Host endpoint engine: address latch, shadow/active wire-in banks,
// wire-out snapshots and the registered read path driving the shared bus.
module first_host_if
  import first_wire_adder_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_i,
  input  logic        rd_i,
  input  logic        addr_i,
  input  logic        upd_wi_i,
  input  logic        upd_wo_i,
  input  logic [15:0] bus_in_i,
  output logic [15:0] bus_out_o,
  output logic        bus_oe_o,
  output logic        rd_valid_o,
  output logic        ready_o,
  output logic [15:0] active00_o,
  output logic [15:0] active01_o,
  output logic [15:0] active02_o,
  input  logic [15:0] ep20_i,
  input  logic [15:0] ep21_i
);

  host_op_e op;

  addr_t addr_q, addr_d;
  word_t sh00_q, sh00_d, sh01_q, sh01_d, sh02_q, sh02_d;
  word_t act00_q, act00_d, act01_q, act01_d, act02_q, act02_d;
  word_t snap20_q, snap20_d, snap21_q, snap21_d;
  word_t rd_data_q, rd_data_d;
  logic  rd_valid_q, rd_valid_d;
  logic  ready_q;

  assign op = decode_op(addr_i, wr_i, rd_i);

  always_comb begin
    addr_d     = addr_q;
    sh00_d     = sh00_q;
    sh01_d     = sh01_q;
    sh02_d     = sh02_q;
    act00_d    = act00_q;
    act01_d    = act01_q;
    act02_d    = act02_q;
    snap20_d   = snap20_q;
    snap21_d   = snap21_q;
    rd_data_d  = '0;
    rd_valid_d = 1'b0;

    unique case (op)
      OP_ADDR:  addr_d = bus_in_i[7:0];
      OP_WRITE: begin
        unique case (addr_q)
          EP_LED:  sh00_d = bus_in_i;
          EP_A:    sh01_d = bus_in_i;
          EP_B:    sh02_d = bus_in_i;
          default: ;
        endcase
      end
      OP_READ: begin
        rd_valid_d = 1'b1;
        unique case (addr_q)
          EP_BTN:  rd_data_d = snap20_q;
          EP_SUM:  rd_data_d = snap21_q;
          default: rd_data_d = '0;
        endcase
      end
      default: ;
    endcase

    // Commits take the pre-edge shadows, so a same-cycle write waits for the next upd_wi
    if (upd_wi_i) begin
      act00_d = sh00_q;
      act01_d = sh01_q;
      act02_d = sh02_q;
    end
    if (upd_wo_i) begin
      snap20_d = ep20_i;
      snap21_d = ep21_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q     <= '0;
      sh00_q     <= '0;
      sh01_q     <= '0;
      sh02_q     <= '0;
      act00_q    <= '0;
      act01_q    <= '0;
      act02_q    <= '0;
      snap20_q   <= '0;
      snap21_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      sh00_q     <= sh00_d;
      sh01_q     <= sh01_d;
      sh02_q     <= sh02_d;
      act00_q    <= act00_d;
      act01_q    <= act01_d;
      act02_q    <= act02_d;
      snap20_q   <= snap20_d;
      snap21_q   <= snap21_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ready_q    <= 1'b1;
    end
  end

  assign bus_out_o  = rd_data_q;
  assign bus_oe_o   = rd_valid_q;
  assign rd_valid_o = rd_valid_q;
  assign ready_o    = ready_q;
  assign active00_o = act00_q;
  assign active01_o = act01_q;
  assign active02_o = act02_q;

endmodule

// File: rtl/first_wire_adder.sv
// Top level: host pins, 16-bit operand adder, LED drive and synchronised
// push-button capture around the host endpoint engine.
module first_wire_adder
  import first_wire_adder_pkg::*;
(
  input  logic [7:0]  hi_in,
  output logic [1:0]  hi_out,
  inout  wire  [15:0] hi_inout,
  output logic [7:0]  led,
  input  logic [3:0]  button
);

  logic  hi_clk;
  logic  hi_rst;
  word_t bus_out;
  logic  bus_oe;
  logic  rd_valid;
  logic  ready;
  word_t active00, active01, active02;
  word_t ep20, ep21;
  logic [3:0] btn_meta_q, btn_sync_q;
  logic  unused_bits;

  assign hi_clk = hi_in[HI_CLK];
  assign hi_rst = hi_in[HI_RST];

  // Buttons are asynchronous to hi_clk; released (high) is the reset state
  always_ff @(posedge hi_clk or posedge hi_rst) begin
    if (hi_rst) begin
      btn_meta_q <= '1;
      btn_sync_q <= '1;
    end else begin
      btn_meta_q <= button;
      btn_sync_q <= btn_meta_q;
    end
  end

  assign ep20 = {12'h000, ~btn_sync_q};
  assign ep21 = active01 + active02;

  first_host_if u_host_if (
    .clk_i      (hi_clk),
    .rst_i      (hi_rst),
    .wr_i       (hi_in[HI_WR]),
    .rd_i       (hi_in[HI_RD]),
    .addr_i     (hi_in[HI_ADDR]),
    .upd_wi_i   (hi_in[HI_UPD_WI]),
    .upd_wo_i   (hi_in[HI_UPD_WO]),
    .bus_in_i   (hi_inout),
    .bus_out_o  (bus_out),
    .bus_oe_o   (bus_oe),
    .rd_valid_o (rd_valid),
    .ready_o    (ready),
    .active00_o (active00),
    .active01_o (active01),
    .active02_o (active02),
    .ep20_i     (ep20),
    .ep21_i     (ep21)
  );

  assign hi_inout    = bus_oe ? bus_out : 'z;
  assign hi_out      = {ready, rd_valid};
  assign led         = ~active00[7:0];
  assign unused_bits = ^{hi_in[7], active00[15:8]};

endmodule

// File: tb/tb_first_wire_adder.sv
// Directed bench for first_wire_adder: host bus transactions with
// hand-computed expectations checked by immediate assertions.
module tb_first_wire_adder;
  import first_wire_adder_pkg::*;

  logic        clk = 1'b0;
  logic        rst, s_wr, s_rd, s_addr, s_upd_wi, s_upd_wo;
  logic        host_oe;
  logic [15:0] host_data;
  logic [3:0]  button;
  logic [7:0]  hi_in;
  logic [1:0]  hi_out;
  logic [7:0]  led;
  wire  [15:0] hi_inout;
  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct { logic [15:0] a; logic [15:0] b; logic [15:0] sum; } vec_t;
  vec_t vecs[5];

  assign hi_in    = {1'b0, s_upd_wo, s_upd_wi, s_addr, s_rd, s_wr, rst, clk};
  assign hi_inout = host_oe ? host_data : 'z;

  first_wire_adder dut (
    .hi_in    (hi_in),
    .hi_out   (hi_out),
    .hi_inout (hi_inout),
    .led      (led),
    .button   (button)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_addr(input addr_t a);
    s_addr = 1'b1; host_oe = 1'b1; host_data = {8'h00, a};
    @(negedge clk);
    s_addr = 1'b0; host_oe = 1'b0;
  endtask

  task automatic do_write(input addr_t a, input logic [15:0] d);
    do_addr(a);
    s_wr = 1'b1; host_oe = 1'b1; host_data = d;
    @(negedge clk);
    s_wr = 1'b0; host_oe = 1'b0;
  endtask

  task automatic do_upd(input logic wi, input logic wo);
    s_upd_wi = wi; s_upd_wo = wo;
    @(negedge clk);
    s_upd_wi = 1'b0; s_upd_wo = 1'b0;
  endtask

  task automatic do_read(input addr_t a, input logic [15:0] exp, input string tag);
    do_addr(a);
    s_rd = 1'b1;
    @(negedge clk);
    s_rd = 1'b0;
    check({tag, "_valid"}, {15'd0, hi_out[0]}, 16'd1);
    check(tag, hi_inout, exp);
    @(negedge clk);
    check({tag, "_done"}, {15'd0, hi_out[0]}, 16'd0);
  endtask

  initial begin
    rst = 1'b1; s_wr = 1'b0; s_rd = 1'b0; s_addr = 1'b0;
    s_upd_wi = 1'b0; s_upd_wo = 1'b0; host_oe = 1'b0; host_data = '0;
    button = 4'hF;
    vecs[0] = '{16'h0001, 16'hFFFF, 16'h0000};
    vecs[1] = '{16'h1111, 16'h2222, 16'h3333};
    vecs[2] = '{16'hABCD, 16'h1234, 16'hBE01};
    vecs[3] = '{16'h7FFF, 16'h0001, 16'h8000};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 16'hFFFE};

    repeat (2) @(negedge clk);
    check("rst_led", {8'h00, led}, 16'h00FF);
    check("rst_rd_valid", {15'd0, hi_out[0]}, 16'd0);
    check("rst_ready", {15'd0, hi_out[1]}, 16'd0);
    rst = 1'b0;
    #1 check("ready_before_edge", {15'd0, hi_out[1]}, 16'd0);
    @(negedge clk);
    check("ready_after_edge", {15'd0, hi_out[1]}, 16'd1);

    do_write(EP_A, 16'h1234);
    do_write(EP_B, 16'h4321);
    do_upd(1'b1, 1'b0);
    do_upd(1'b0, 1'b1);
    do_read(EP_SUM, 16'h5555, "add");

    do_write(EP_A, 16'hFFFF);
    do_write(EP_B, 16'h0002);
    do_upd(1'b1, 1'b0);
    do_upd(1'b0, 1'b1);
    do_read(EP_SUM, 16'h0001, "ovf_ffff_2");
    do_write(EP_A, 16'h8000);
    do_write(EP_B, 16'h8000);
    do_upd(1'b1, 1'b0);
    do_upd(1'b0, 1'b1);
    do_read(EP_SUM, 16'h0000, "ovf_8000_8000");

    do_write(EP_A, 16'h0005);
    do_upd(1'b0, 1'b1);
    do_read(EP_SUM, 16'h0000, "stage_no_commit");
    do_upd(1'b1, 1'b0);
    do_upd(1'b0, 1'b1);
    do_read(EP_SUM, 16'h8005, "stage_commit");
    do_write(EP_B, 16'h0001);
    do_upd(1'b1, 1'b1);
    do_read(EP_SUM, 16'h8005, "stage_same_cycle");
    do_upd(1'b0, 1'b1);
    do_read(EP_SUM, 16'h0006, "stage_after");

    button = 4'b1010;
    repeat (2) @(negedge clk);
    do_upd(1'b0, 1'b1);
    do_read(EP_BTN, 16'h0005, "buttons");
    do_write(EP_LED, 16'h00A5);
    check("led_before_commit", {8'h00, led}, 16'h00FF);
    do_upd(1'b1, 1'b0);
    check("led_a5", {8'h00, led}, 16'h005A);

    do_read(8'h33, 16'h0000, "read_unmapped");
    do_write(EP_SUM, 16'hBEEF);
    do_upd(1'b1, 1'b0);
    do_upd(1'b0, 1'b1);
    do_read(EP_SUM, 16'h0006, "write_ro_ignored");

    do_addr(EP_A);
    s_wr = 1'b1; s_rd = 1'b1; host_oe = 1'b1; host_data = 16'h0010;
    @(negedge clk);
    s_wr = 1'b0; s_rd = 1'b0; host_oe = 1'b0;
    check("wr_rd_no_valid", {15'd0, hi_out[0]}, 16'd0);
    do_upd(1'b1, 1'b0);
    do_upd(1'b0, 1'b1);
    do_read(EP_SUM, 16'h0011, "wr_rd_write_taken");

    do_addr(EP_SUM);
    s_rd = 1'b1;
    @(negedge clk);
    check("b2b_first", hi_inout, 16'h0011);
    @(negedge clk);
    s_rd = 1'b0;
    check("b2b_second_valid", {15'd0, hi_out[0]}, 16'd1);
    check("b2b_second", hi_inout, 16'h0011);
    @(negedge clk);

    foreach (vecs[i]) begin
      do_write(EP_A, vecs[i].a);
      do_write(EP_B, vecs[i].b);
      do_upd(1'b1, 1'b0);
      do_upd(1'b0, 1'b1);
      do_read(EP_SUM, vecs[i].sum, $sformatf("vec%0d", i));
    end

    do_addr(EP_SUM);
    s_rd = 1'b1;
    @(negedge clk);
    s_rd = 1'b0;
    check("midrst_pending", {15'd0, hi_out[0]}, 16'd1);
    #1 rst = 1'b1;
    #1 check("midrst_rd_valid", {15'd0, hi_out[0]}, 16'd0);
    check("midrst_ready", {15'd0, hi_out[1]}, 16'd0);
    check("midrst_led", {8'h00, led}, 16'h00FF);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("midrst_ready_held", {15'd0, hi_out[1]}, 16'd0);
    @(negedge clk);
    check("midrst_ready_back", {15'd0, hi_out[1]}, 16'd1);
    do_read(EP_SUM, 16'h0000, "midrst_snap_cleared");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
